ysyx_23060096_alu_arbiter: RTL and testbench
============================================

Name: ysyx_23060096_alu_arbiter

Overview:
Shares one 4-bit ALU between two requesters using round-robin arbitration and valid/ready handshakes. It registers the granted request's operands and opcode and drives them to the ALU. It then captures the ALU result and returns it on the owning requester's response channel. It sits between two issuing units and the ALU. The ALU stays purely combinational; all sequencing lives in this block.

Parameters:
WIDTH, 4, operand/result width (matches ALU A/B/out)
OPW, 3, opcode width (matches ALU op)
CNTW, 8, width of completed-operation counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  operand A, requester 0
req0_b  in  WIDTH  operand B, requester 0
req0_op  in  OPW  ALU opcode, requester 0
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes result
rsp0_data  out  WIDTH  result for requester 0
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
rsp1_valid / rsp1_ready / rsp1_data  same as requester 0, for requester 1
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_op  out  OPW  to ALU op
alu_out  in  WIDTH  from ALU out
busy  out  1  state != IDLE
last_grant  out  1  id of last completed requester
op_count  out  CNTW  completed-operation count

Behaviour:
- Clock port clk; reset port rst is synchronous and active-high. There is one clock domain.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- Reset values: state=IDLE, alu_a/alu_b/alu_op=0, result=0, owner=0, last_grant=1 (requester 0 wins first tie), op_count=0, rsp0/1_valid=0, rsp0/1_data=0, busy=0.
- While rst=1, req0_ready and req1_ready are 0.
- IDLE arbitration:
  - One valid requester: it is granted.
  - Both valid: the requester != last_grant is granted.
- reqN_ready is combinational: it is 1 only for the granted requester, only in IDLE, and only when rst=0. The other requester's ready is 0.
- Handshake (valid & ready at an edge) latches a, b, op into registers alu_a/alu_b/alu_op and the id into owner. Next state is EXEC.
- EXEC (exactly 1 cycle): the ALU sees the registered operands. At the edge, alu_out is captured into result. Next state is RESP.
- RESP: rsp[owner]_valid=1 and rsp[owner]_data=result. The other response channel has valid=0 and data=0.
- rsp_valid and rsp_data stay stable until rsp[owner]_ready=1 at an edge. At that edge:
  - last_grant <= owner
  - op_count <= op_count+1, wrapping 2^CNTW-1 -> 0
  - next state IDLE
- Latency: request accepted at edge E0; rsp_valid is high after edge E0+2. Minimum issue interval is 3 cycles; a new grant is possible in the IDLE cycle after the response handshake.
- alu_a/alu_b/alu_op hold their last values outside EXEC; they are not cleared.
- Results are passed through unmodified. This includes opcodes 110/111, whose ALU output is 0 or 1 zero-extended to WIDTH.
- Requester rules: valid must not depend on ready. Payload must be held stable while valid=1 and ready=0. Changing the payload before the handshake is allowed; the value sampled at the handshake edge is used.
- Reset mid-operation (EXEC or RESP): the transaction is dropped and no response is issued. All registers return to reset values. last_grant returns to 1.
- rsp_ready asserted outside RESP, or on the non-owner channel, is ignored.

Test Plan:
- Single op: req0 a=4'h3, b=4'h5, op=000 -> req0_ready=1 in the same cycle; rsp0_valid=1 two edges later with rsp0_data=4'h8; op_count=1; last_grant=0.
- Tie after reset: req0 and req1 both valid (req0: a=6, b=2, op=001; req1: a=4'hC, b=4'hA, op=011) -> req0 granted first, rsp0_data=4'h4; then req1 granted, rsp1_data=4'h8; last_grant sequence 0, 1.
- Response backpressure: hold rsp1_ready=0 for 5 cycles with result 4'hF (a=4'h5, b=4'hA, op=100) -> rsp1_valid and data stable all 5 cycles; req0_ready=0 throughout; busy=1.
- Alternation under saturation: both requesters valid continuously for 6 ops -> grants alternate 0, 1, 0, 1, 0, 1; one op every 3 cycles with rsp_ready tied 1; op_count=6.
- Reset in EXEC: assert rst for one cycle after accepting req0 -> no rsp0_valid; state=IDLE; op_count=0; last_grant=1; alu_a=alu_b=alu_op=0.
- Counter wrap (CNTW=8): 256 completed ops -> op_count returns to 0. Also: compare op (a=4'h7, b=4'h7, op=111) -> rsp_data=4'h1.

Source files
------------

// File: rtl/ysyx_23060096_alu_arbiter_if.sv
// Request/response channels of both requesters plus the ALU connection.
// The slave modport faces the arbiter; the master modport faces requesters and the ALU.
interface ysyx_23060096_alu_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [OPW-1:0]   req0_op;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [OPW-1:0]   req1_op;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_out;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    input  alu_out,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output alu_a, alu_b, alu_op
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
    output alu_out,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/ysyx_23060096_alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Grant in IDLE, one EXEC cycle to capture the ALU result, hold in RESP until taken.
module ysyx_23060096_alu_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 3,
  parameter int unsigned CNTW  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  ysyx_23060096_alu_arbiter_if.slave       bus,
  output logic                             busy,
  output logic                             last_grant,
  output logic [CNTW-1:0]                  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             owner;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [OPW-1:0]   alu_op_q;

  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic             rsp_hs;

  // Arbitration and handshake decode; ready is suppressed during reset.
  always_comb begin
    grant_valid    = bus.req0_valid | bus.req1_valid;
    grant_id       = 1'b0;
    next_state     = state;
    accept         = 1'b0;
    rsp_hs         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp0_data  = '0;
    bus.rsp1_data  = '0;

    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end

    case (state)
      IDLE: begin
        if (!rst && grant_valid) begin
          bus.req0_ready = (grant_id == 1'b0);
          bus.req1_ready = (grant_id == 1'b1);
          accept         = 1'b1;
          next_state     = EXEC;
        end
      end
      EXEC: begin
        next_state = RESP;
      end
      RESP: begin
        if (owner == 1'b0) begin
          bus.rsp0_valid = 1'b1;
          bus.rsp0_data  = result;
          rsp_hs         = bus.rsp0_ready;
        end else begin
          bus.rsp1_valid = 1'b1;
          bus.rsp1_data  = result;
          rsp_hs         = bus.rsp1_ready;
        end
        if (rsp_hs) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      result     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_count   <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        owner <= grant_id;
        if (grant_id) begin
          alu_a_q  <= bus.req1_a;
          alu_b_q  <= bus.req1_b;
          alu_op_q <= bus.req1_op;
        end else begin
          alu_a_q  <= bus.req0_a;
          alu_b_q  <= bus.req0_b;
          alu_op_q <= bus.req0_op;
        end
      end
      if (state == EXEC) begin
        result <= bus.alu_out;
      end
      if (rsp_hs) begin
        last_grant <= owner;
        op_count   <= op_count + CNTW'(1);
      end
    end
  end

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ysyx_23060096_alu_arbiter.sv
// Directed bench for the ALU arbiter; the ALU itself is modelled here.
module tb_ysyx_23060096_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       last_grant;
  logic [7:0] op_count;

  int unsigned vectors;
  int unsigned miscompares;

  ysyx_23060096_alu_arbiter_if #(.WIDTH(4), .OPW(3)) bus ();

  ysyx_23060096_alu_arbiter #(.WIDTH(4), .OPW(3), .CNTW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy),
    .last_grant (last_grant),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return ~a;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a ^ b;
      3'b110:  return {3'b000, (a < b)};
      default: return {3'b000, (a == b)};
    endcase
  endfunction

  always_comb bus.alu_out = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.req0_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready0: got %b expected 0", bus.req0_ready);
    end
    bus.req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || last_grant !== 1'b1 || op_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b last_grant=%b op_count=%0d expected 0 1 0",
               busy, last_grant, op_count);
    end
    vectors++;
    if (bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0 || bus.alu_op !== 3'h0 ||
        bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 ||
        bus.rsp0_data !== 4'h0 || bus.rsp1_data !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: alu=%h/%h/%h rsp_valid=%b%b rsp_data=%h/%h expected all 0",
               bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp0_valid, bus.rsp1_valid,
               bus.rsp0_data, bus.rsp1_data);
    end
  endtask

  task automatic test_single_op();
    bus.req0_a = 4'h3; bus.req0_b = 4'h5; bus.req0_op = 3'b000; bus.req0_valid = 1'b1;
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready: got %b%b expected req0=1 req1=0", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || bus.alu_a !== 4'h3 || bus.alu_b !== 4'h5 || bus.rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_exec: busy=%b alu_a=%h alu_b=%h rsp0_valid=%b expected 1 3 5 0",
               busy, bus.alu_a, bus.alu_b, bus.rsp0_valid);
    end
    tick();
    vectors++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 4'h8 ||
        bus.rsp1_valid !== 1'b0 || bus.rsp1_data !== 4'h0) begin
      miscompares++;
      $display("FAIL single_rsp: rsp0=%b/%h rsp1=%b/%h expected 1/8 0/0",
               bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid, bus.rsp1_data);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    vectors++;
    if (op_count !== 8'd1 || last_grant !== 1'b0 || busy !== 1'b0 || bus.rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: op_count=%0d last_grant=%b busy=%b rsp0_valid=%b expected 1 0 0 0",
               op_count, last_grant, busy, bus.rsp0_valid);
    end
  endtask

  task automatic test_tie();
    pulse_reset();
    bus.req0_a = 4'h6; bus.req0_b = 4'h2; bus.req0_op = 3'b001; bus.req0_valid = 1'b1;
    bus.req1_a = 4'hC; bus.req1_b = 4'hA; bus.req1_op = 3'b011; bus.req1_valid = 1'b1;
    #1;
    vectors++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_first_grant: got %b%b expected req0=1 req1=0", bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req0_valid = 1'b0;
    tick();
    vectors++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 4'h4) begin
      miscompares++;
      $display("FAIL tie_rsp0: got %b/%h expected 1/4", bus.rsp0_valid, bus.rsp0_data);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    vectors++;
    if (last_grant !== 1'b0 || bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_second_grant: last_grant=%b ready=%b%b expected 0 req0=0 req1=1",
               last_grant, bus.req0_ready, bus.req1_ready);
    end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    vectors++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 4'h8 || bus.rsp0_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_rsp1: got %b/%h rsp0_valid=%b expected 1/8 0",
               bus.rsp1_valid, bus.rsp1_data, bus.rsp0_valid);
    end
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
    vectors++;
    if (last_grant !== 1'b1 || op_count !== 8'd2) begin
      miscompares++;
      $display("FAIL tie_done: last_grant=%b op_count=%0d expected 1 2", last_grant, op_count);
    end
  endtask

  task automatic test_backpressure();
    bus.req1_a = 4'h5; bus.req1_b = 4'hA; bus.req1_op = 3'b100; bus.req1_valid = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.req0_op = 3'b000; bus.req0_valid = 1'b1;
    tick();
    // Non-owner ready must not release the held response.
    bus.rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 4'hF || bus.req0_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: rsp1=%b/%h req0_ready=%b busy=%b expected 1/f 0 1",
                 i, bus.rsp1_valid, bus.rsp1_data, bus.req0_ready, busy);
      end
      tick();
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;
    vectors++;
    if (op_count !== 8'd3 || bus.req0_ready !== 1'b1 || bus.rsp1_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release: op_count=%0d req0_ready=%b rsp1_valid=%b expected 3 1 0",
               op_count, bus.req0_ready, bus.rsp1_valid);
    end
    tick();
    bus.req0_valid = 1'b0;
    tick();
    vectors++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 4'h2) begin
      miscompares++;
      $display("FAIL backpressure_next: got %b/%h expected 1/2", bus.rsp0_valid, bus.rsp0_data);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic exp_g;
    pulse_reset();
    bus.req0_a = 4'h2; bus.req0_b = 4'h3; bus.req0_op = 3'b000; bus.req0_valid = 1'b1;
    bus.req1_a = 4'h9; bus.req1_b = 4'h2; bus.req1_op = 3'b001; bus.req1_valid = 1'b1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      exp_g = k[0];
      vectors++;
      if (bus.req0_ready !== ~exp_g || bus.req1_ready !== exp_g) begin
        miscompares++;
        $display("FAIL sat_grant[%0d]: ready=%b%b expected req%0d only", k,
                 bus.req0_ready, bus.req1_ready, exp_g);
      end
      tick();
      tick();
      vectors++;
      if (exp_g == 1'b0 ? (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 4'h5)
                        : (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 4'h7)) begin
        miscompares++;
        $display("FAIL sat_rsp[%0d]: rsp0=%b/%h rsp1=%b/%h expected req%0d result",
                 k, bus.rsp0_valid, bus.rsp0_data, bus.rsp1_valid, bus.rsp1_data, exp_g);
      end
      tick();
    end
    vectors++;
    if (op_count !== 8'd6 || last_grant !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_done: op_count=%0d last_grant=%b expected 6 1", op_count, last_grant);
    end
    idle_inputs();
  endtask

  task automatic test_reset_exec();
    bus.req0_a = 4'hB; bus.req0_b = 4'hD; bus.req0_op = 3'b010; bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    pulse_reset();
    #1;
    vectors++;
    if (busy !== 1'b0 || op_count !== 8'd0 || last_grant !== 1'b1 ||
        bus.alu_a !== 4'h0 || bus.alu_b !== 4'h0 || bus.alu_op !== 3'h0) begin
      miscompares++;
      $display("FAIL reset_exec_state: busy=%b op_count=%0d last_grant=%b alu=%h/%h/%h expected 0 0 1 0/0/0",
               busy, op_count, last_grant, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    tick();
    tick();
    vectors++;
    if (bus.rsp0_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_exec_norsp: rsp0_valid=%b busy=%b expected 0 0", bus.rsp0_valid, busy);
    end
  endtask

  task automatic test_compare_wrap();
    bus.req0_a = 4'h7; bus.req0_b = 4'h7; bus.req0_op = 3'b111; bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    vectors++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 4'h1) begin
      miscompares++;
      $display("FAIL compare_eq: got %b/%h expected 1/1", bus.rsp0_valid, bus.rsp0_data);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    bus.req0_op = 3'b000;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 254 * 3; i++) tick();
    vectors++;
    if (op_count !== 8'd255) begin
      miscompares++;
      $display("FAIL wrap_pre: op_count=%0d expected 255", op_count);
    end
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (op_count !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: op_count=%0d busy=%b expected 0 0", op_count, busy);
    end
    idle_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_op();
    test_tie();
    test_backpressure();
    test_saturation();
    test_reset_exec();
    test_compare_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
